// File: rtl/rdy_val_pkg.sv
// Shared helpers for the ready/valid elastic buffer: counter/pointer widths
// and the modulo-DEPTH pointer advance used by both buffer pointers.
package rdy_val_pkg;

   // Width of an occupancy counter that must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a pointer addressing 0..depth-1 (depth >= 2, so never zero).
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   // Next pointer value; wraps from depth-1 to 0 without a power-of-two assumption.
   function automatic int ptr_wrap(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rdy_val_buf_ptr.sv
// Wrapping modulo-DEPTH pointer with increment enable and synchronous reset.
// Used for both the write and the read side of the buffer.
module rdy_val_buf_ptr
   import rdy_val_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   // Advance by one on inc, wrapping at DEPTH-1; reset returns to slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= PW'(ptr_wrap(int'(ptr), DEPTH));
      end
   end

endmodule

// File: rtl/rdy_val_fifo_buf.sv
// Parametrised ready/valid elastic buffer holding up to DEPTH beats.
// b_rdy is a register computed from next occupancy, so it has no
// combinational dependence on r_rdy and cuts the ready path.
// Optional macro RDY_VAL_FIFO_BUF_BYPASS_EN: when empty with t_val and r_rdy
// both high, the beat passes straight from t_* to b_* with zero latency.
//
// Handshake: a beat transfers on a rising edge when valid and ready are both
// high on that interface (push = t_val & b_rdy, pop = b_val & r_rdy); while
// b_val=1 and r_rdy=0, b_val and b_data hold steady.
module rdy_val_fifo_buf
   import rdy_val_pkg::*;
#(
   parameter int BW    = 8,
   parameter int DEPTH = 4,
   localparam int CW   = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          t_val,
   input  logic [BW-1:0] t_data,
   output logic          b_rdy,
   input  logic          r_rdy,
   output logic          b_val,
   output logic [BW-1:0] b_data,
   output logic [CW-1:0] count
);

   localparam int PW = ptr_width(DEPTH);

   // Beat presented downstream.
   typedef struct packed {
      logic          valid;
      logic [BW-1:0] data;
   } beat_t;

   logic [BW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_next;
   logic          b_rdy_q;
   logic          stored_val;
   logic          byp;
   logic          push;
   logic          pop;
   beat_t         out_beat;

   assign stored_val = (count_q != '0);

`ifdef RDY_VAL_FIFO_BUF_BYPASS_EN
   // Empty buffer with both sides ready: hand the beat straight through.
   assign byp = ~stored_val & t_val & r_rdy;
`else
   assign byp = 1'b0;
`endif

   // Inputs are ignored while rst is high; a bypassed beat is never stored.
   assign push = ~rst & t_val & b_rdy_q & ~byp;
   assign pop  = ~rst & stored_val & r_rdy;

   rdy_val_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (push),
      .ptr (wr_ptr)
   );

   rdy_val_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (pop),
      .ptr (rd_ptr)
   );

   // Next occupancy: push-only grows, pop-only shrinks, both or neither holds.
   always_comb begin
      count_next = count_q;
      case ({push, pop})
         2'b10:   count_next = count_q + CW'(1);
         2'b01:   count_next = count_q - CW'(1);
         default: count_next = count_q;
      endcase
   end

   // Occupancy and registered ready; ready looks at next occupancy only.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         b_rdy_q <= 1'b1;
      end else begin
         count_q <= count_next;
         b_rdy_q <= (count_next < CW'(DEPTH));
      end
   end

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= t_data;
      end
   end

   // Output beat: head of storage, or the incoming beat when bypassing.
   always_comb begin
      out_beat.valid = stored_val;
      out_beat.data  = mem[rd_ptr];
      if (byp) begin
         out_beat.valid = 1'b1;
         out_beat.data  = t_data;
      end
   end

   assign b_rdy  = b_rdy_q;
   assign b_val  = out_beat.valid;
   assign b_data = out_beat.data;
   assign count  = count_q;

endmodule

// File: tb/tb_rdy_val_fifo_buf.sv
// Bench for rdy_val_fifo_buf: one DEPTH=4 and one DEPTH=3 instance, each
// checked every cycle against a queue model of the buffer.
module tb_rdy_val_fifo_buf;

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b00;
   logic [1:0] t_val = 2'b00;
   logic [1:0] r_rdy = 2'b00;
   logic [7:0] t_data [2];
   logic [1:0] b_rdy;
   logic [1:0] b_val;
   logic [7:0] b_data [2];
   logic [2:0] count0;
   logic [1:0] count1;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [1:0] m_rdy = 2'b11;
   int         n_chk = 0;
   int         n_bad = 0;

   // Clock
   always #5 clk = ~clk;

   rdy_val_fifo_buf #(.BW(8), .DEPTH(4)) dut4 (
      .clk    (clk),
      .rst    (rst[0]),
      .t_val  (t_val[0]),
      .t_data (t_data[0]),
      .b_rdy  (b_rdy[0]),
      .r_rdy  (r_rdy[0]),
      .b_val  (b_val[0]),
      .b_data (b_data[0]),
      .count  (count0)
   );

   rdy_val_fifo_buf #(.BW(8), .DEPTH(3)) dut3 (
      .clk    (clk),
      .rst    (rst[1]),
      .t_val  (t_val[1]),
      .t_data (t_data[1]),
      .b_rdy  (b_rdy[1]),
      .r_rdy  (r_rdy[1]),
      .b_val  (b_val[1]),
      .b_data (b_data[1]),
      .count  (count1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int q_size(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [7:0] q_front(input int d);
      return (d == 0) ? exp_q0[0] : exp_q1[0];
   endfunction

   // One clock cycle on instance d: drive, compare with the model, update it.
   task automatic step(input int d, input logic rst_i, input logic tv,
                       input logic [7:0] td, input logic rr);
      int         sz;
      int         depth;
      int         cnt;
      logic       byp;
      logic       exp_val;
      logic       do_push;
      logic       do_pop;
      @(negedge clk);
      rst[d]    = rst_i;
      t_val[d]  = tv;
      t_data[d] = td;
      r_rdy[d]  = rr;
      #1;
      depth = (d == 0) ? 4 : 3;
      if (rst_i) begin
         if (d == 0) exp_q0.delete(); else exp_q1.delete();
         m_rdy[d] = 1'b1;
      end else begin
         sz  = q_size(d);
         cnt = (d == 0) ? int'(count0) : int'(count1);
         byp = 1'b0;
`ifdef RDY_VAL_FIFO_BUF_BYPASS_EN
         byp = (sz == 0) && tv && rr;
`endif
         exp_val = (sz != 0) || byp;
         check($sformatf("d%0d b_rdy", d), 32'(b_rdy[d]), 32'(m_rdy[d]));
         check($sformatf("d%0d b_val", d), 32'(b_val[d]), 32'(exp_val));
         check($sformatf("d%0d count", d), 32'(cnt), 32'(sz));
         if (exp_val)
            check($sformatf("d%0d b_data", d), 32'(b_data[d]), byp ? 32'(td) : 32'(q_front(d)));
         do_push = tv && m_rdy[d] && !byp;
         do_pop  = rr && (sz != 0);
         if (do_pop) begin
            if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
         end
         if (do_push) begin
            if (d == 0) exp_q0.push_back(td); else exp_q1.push_back(td);
         end
         m_rdy[d] = (q_size(d) < depth);
      end
   endtask

   task automatic drain(input int d, input int n);
      for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      t_data[0] = 8'h00;
      t_data[1] = 8'h00;

      // Reset then a single beat with downstream stalled
      step(0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(0, 1'b0, 1'b1, 8'hA5, 1'b0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b0);
      drain(0, 2);

      // Fill past full, then drain in order
      for (int i = 1; i <= 6; i++) step(0, 1'b0, 1'b1, 8'(i), 1'b0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b0);
      drain(0, 6);

      // Streaming at one beat per cycle
      for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
      drain(0, 3);

      // Full with a simultaneous pop attempt, then the freed slot is reused
      for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
      step(0, 1'b0, 1'b1, 8'h14, 1'b1);
      step(0, 1'b0, 1'b1, 8'h15, 1'b0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b0);
      drain(0, 6);

      // Reset mid-stream at count 2, then confirm pointers realigned
      step(0, 1'b0, 1'b1, 8'h21, 1'b0);
      step(0, 1'b0, 1'b1, 8'h22, 1'b0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(0, 1'b1, 1'b1, 8'h23, 1'b1);
      step(0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(0, 1'b0, 1'b1, 8'h77, 1'b0);
      drain(0, 2);

      // Empty with both sides ready (pass-through when bypass is built in)
      step(0, 1'b0, 1'b1, 8'h3C, 1'b1);
      drain(0, 2);

      // DEPTH=3 wrap-around under random traffic
      step(1, 1'b1, 1'b0, 8'h00, 1'b0);
      step(1, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 500; i++)
         step(1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      drain(1, 4);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
